// File: rtl/prod_accumulator.sv
// prod_accumulator
//   Accumulates COUNT signed products from the registered multiplier into one
//   block sum. It then rounds half up, arithmetically shifts right by SHIFT and
//   saturates the result to OUT_W bits. Both sides use a valid/ready handshake.
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   clear      in   synchronous abort of the current block
//   in_valid   in   in_data carries a product
//   in_ready   out  a product can be accepted this cycle
//   in_data    in   signed product [IN_W-1:0]
//   out_valid  out  out_data/out_sat hold a finished block result
//   out_ready  in   consumer takes the result this cycle
//   out_data   out  rounded, scaled, saturated block sum [OUT_W-1:0]
//   out_sat    out  out_data was clipped to an OUT_W limit
module prod_accumulator #(
  parameter int IN_W  = 19,
  parameter int ACC_W = 24,
  parameter int OUT_W = 16,
  parameter int COUNT = 8,
  parameter int SHIFT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam int RND_I = (1 << SHIFT) >> 1;
  localparam logic signed [ACC_W:0] RND_V = (ACC_W+1)'(RND_I);
  localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ACC_W-1:0]        r_acc;
  logic [ACC_W-1:0]        w_acc_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic [ACC_W-1:0]        w_ext;
  logic                    w_accept;
  logic                    w_load;
  logic signed [ACC_W:0]   w_rnd;
  logic signed [ACC_W:0]   w_r;
  logic [OUT_W-1:0]        r_out_data;
  logic                    r_out_sat;
  logic [OUT_W-1:0]        w_res_data;
  logic                    w_res_sat;

  assign in_ready  = (r_state != DONE) | out_ready;
  assign out_valid = (r_state == DONE);
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

  assign w_accept  = in_valid & in_ready;
  assign w_ext     = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    case (r_state)
      // In DONE an accept implies out_ready, so starting a new block there is
      // the same as starting one from IDLE.
      IDLE, DONE: begin
        if (w_accept) begin
          w_acc_nxt = w_ext;
          w_cnt_nxt = CNT_W'(1);
          if (COUNT == 1) begin
            w_state_nxt = DONE;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = ACCUM;
          end
        end else if (r_state == DONE && out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      ACCUM: begin
        if (w_accept) begin
          w_acc_nxt = r_acc + w_ext;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CNT_W'(COUNT)) begin
            w_state_nxt = DONE;
            w_load      = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Result is formed from the post-accept sum, so it includes the final product.
  // One extra bit keeps the rounding add from wrapping.
  always_comb begin
    w_rnd = $signed({w_acc_nxt[ACC_W-1], w_acc_nxt}) + RND_V;
    w_r   = w_rnd >>> SHIFT;
    if (w_r > MAX_V) begin
      w_res_data = {1'b0, {(OUT_W-1){1'b1}}};
      w_res_sat  = 1'b1;
    end else if (w_r < MIN_V) begin
      w_res_data = {1'b1, {(OUT_W-1){1'b0}}};
      w_res_sat  = 1'b1;
    end else begin
      w_res_data = w_r[OUT_W-1:0];
      w_res_sat  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else if (clear) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_out_data <= w_res_data;
        r_out_sat  <= w_res_sat;
      end
    end
  end

endmodule

// File: tb/tb_prod_accumulator.sv
module tb_prod_accumulator;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clear = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [18:0] in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [15:0]        out_data;
  logic               out_sat;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_d[$];
  logic        exp_s[$];
  longint      blk_sum = 0;
  int          blk_n   = 0;
  logic        rand_rdy = 1'b0;

  prod_accumulator #(
    .IN_W (19),
    .ACC_W(24),
    .OUT_W(16),
    .COUNT(8),
    .SHIFT(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: floor((sum + 4) / 8), then clamp to the signed 16-bit range.
  function automatic void push_expected(input longint s);
    longint t, r;
    t = s + 4;
    if (t >= 0) r = t / 8;
    else        r = -((-t + 7) / 8);
    if (r > 32767) begin
      exp_d.push_back(16'h7FFF); exp_s.push_back(1'b1);
    end else if (r < -32768) begin
      exp_d.push_back(16'h8000); exp_s.push_back(1'b1);
    end else begin
      exp_d.push_back(16'(r)); exp_s.push_back(1'b0);
    end
  endfunction

  function automatic void model_accept(input logic signed [18:0] v);
    blk_sum += longint'(v);
    blk_n++;
    if (blk_n == 8) begin
      push_expected(blk_sum);
      blk_sum = 0;
      blk_n   = 0;
    end
  endfunction

  function automatic void model_flush();
    blk_sum = 0;
    blk_n   = 0;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the product was taken.
  task automatic send(input logic signed [18:0] v);
    int n;
    in_valid = 1'b1;
    in_data  = v;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready stayed %0d, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (n < 200) model_accept(v);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_block(input logic signed [18:0] first, input logic signed [18:0] rest);
    send(first);
    for (int i = 1; i < 8; i++) send(rest);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_d.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_queue_empty", exp_d.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_d.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out: out_data=%0h with nothing expected", out_data);
      end else begin
        logic [15:0] d;
        logic        s;
        d = exp_d.pop_front();
        s = exp_s.pop_front();
        check("sb_out_data", out_data, d);
        check("sb_out_sat", out_sat, s);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    // Reset values
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    check("rst_in_ready", in_ready, 1);

    // 1: back-to-back 100s, result one cycle after the 8th accept
    send_block(19'sd100, 19'sd100);
    check("t1_latency_valid", out_valid, 1);
    drain();

    // 2: saturation both ways
    send_block(19'sh3FFFF, 19'sh3FFFF);
    drain();
    send_block(19'sh40000, 19'sh40000);
    drain();

    // 3: rounding
    send_block(19'sd3, 19'sd0);
    send_block(19'sd4, 19'sd0);
    send_block(-19'sd4, 19'sd0);
    send_block(-19'sd5, 19'sd0);
    drain();

    // 4: backpressure, then accept on the handshake cycle
    for (int i = 0; i < 7; i++) send(19'sd40);
    out_ready = 1'b0;
    send(19'sd40);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_in_ready", in_ready, 0);
      check("t4_hold_data", out_data, 40);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(19'sd7);
    for (int i = 0; i < 7; i++) send(19'sd9);
    drain();

    // 5: clear mid-block drops partial sum and the product offered with it
    for (int i = 0; i < 4; i++) send(19'sd50);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 19'sd123;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    model_flush();
    check("t5_clear_valid", out_valid, 0);
    idle(1);
    check("t5_clear_valid2", out_valid, 0);
    send_block(19'sd16, 19'sd16);
    drain();

    // 6: asynchronous reset mid-cycle during ACCUM
    for (int i = 0; i < 3; i++) send(19'sd30);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", out_valid, 0);
    check("t6_async_data", out_data, 0);
    check("t6_async_sat", out_sat, 0);
    model_flush();
    idle(2);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_in_ready", in_ready, 1);
    send_block(-19'sd24, -19'sd24);
    drain();

    // Random products, random gaps, random backpressure
    rand_rdy = 1'b1;
    for (int b = 0; b < 20; b++) begin
      for (int k = 0; k < 8; k++) begin
        logic signed [18:0] v;
        v = 19'($urandom);
        if (b < 10) v = 19'($signed(v) >>> 8);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        send(v);
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
